// File: rtl/ub_skew_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ub_skew_feeder_pkg
// Description : Shared widths and sequencer state encoding for the
//               unified-buffer to systolic-array skew feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package ub_skew_feeder_pkg;

    localparam int WORD_SIZE = 32;  // SRAM word width, equals LANES*LANE_W
    localparam int LANES     = 4;   // array rows fed in parallel
    localparam int LANE_W    = 8;   // bits per lane element
    localparam int ADDR_W    = 16;  // byte address width
    localparam int CNT_W     = 16;  // word counter width

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/skew_lane_delay.sv
`default_nettype none
// ============================================================================
// Module      : skew_lane_delay
// Description : DEPTH-stage data/valid shift chain with a shared advance
//               enable. o_pending flags valid beats still upstream of the
//               final stage, so the owner can tell when the chain drains.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_lane_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_pending
);

    logic [W-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic             w_pend;

    // Shift chain; holds every stage while the enable is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
        end else if (i_en) begin
            r_data[0]  <= i_data;
            r_valid[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i]  <= r_data[i-1];
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Any valid beat in a stage other than the last one
    always_comb begin
        w_pend = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_pend = w_pend | r_valid[i];
        end
    end

    assign o_data    = r_data[DEPTH-1];
    assign o_valid   = r_valid[DEPTH-1];
    assign o_pending = w_pend;

endmodule
`default_nettype wire

// File: rtl/ub_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : ub_skew_feeder
// Description : Streams consecutive words out of the unified buffer through a
//               2-entry prefetch FIFO and applies the diagonal lane skew the
//               systolic array expects (lane k delayed k cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module ub_skew_feeder
    import ub_skew_feeder_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     num_words,
    output logic                 busy,
    output logic                 done,
    output logic                 sram_wen,
    output logic [ADDR_W-1:0]    sram_addr,
    input  logic [WORD_SIZE-1:0] sram_rdata,
    input  logic                 stall,
    output logic [WORD_SIZE-1:0] out_data,
    output logic [LANES-1:0]     out_lane_valid
);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [ADDR_W-1:0]    r_next_addr;
    logic [ADDR_W-1:0]    r_last_addr;
    logic [CNT_W-1:0]     r_num;
    logic [CNT_W-1:0]     r_issued;
    logic                 r_inflight;
    logic [WORD_SIZE-1:0] r_fifo [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;
    logic [WORD_SIZE-1:0] r_inj_data;
    logic [LANES-1:0]     r_inj_valid;

    logic                 w_accept;
    logic                 w_issue;
    logic                 w_avail;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_fifo_rd;
    logic [WORD_SIZE-1:0] w_head;
    logic [LANE_W-1:0]    w_lane_data [LANES];
    logic [LANES-1:0]     w_lane_valid;
    logic [LANES-1:0]     w_lane_pend;
    logic                 w_pipe_pending;
    logic                 w_unused;

    // Word alignment is forced, so the low address bits carry no information
    assign w_unused = &{1'b0, base_addr[1:0]};

    assign w_accept = (r_state == ST_IDLE) && start;
    // At most two words buffered or in flight, so the FIFO can never overflow
    assign w_issue  = (r_state == ST_RUN) && ((r_count + {1'b0, r_inflight}) < 2'd2)
                      && (r_issued < r_num);
    // Returning SRAM data bypasses an empty FIFO so word 0 pops the cycle it lands
    assign w_avail   = (r_count != 2'd0) || r_inflight;
    assign w_head    = (r_count != 2'd0) ? r_fifo[r_rd_ptr] : sram_rdata;
    assign w_pop     = !stall && w_avail;
    assign w_fifo_rd = w_pop && (r_count != 2'd0);
    assign w_push    = r_inflight && !(w_pop && (r_count == 2'd0));

    assign busy      = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign done      = (r_state == ST_DONE);
    assign sram_wen  = 1'b0;
    // The bus shows the issuing address, otherwise it parks on the last one used
    assign sram_addr = w_issue ? r_next_addr : r_last_addr;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: drain completes when nothing but the final lane stages hold data
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_words == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if ((r_issued == r_num) && !r_inflight) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if ((r_count == 2'd0) && !r_inflight && !stall && !w_pipe_pending) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Read issue: address generation, word count and one-cycle in-flight flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_next_addr <= '0;
            r_last_addr <= '0;
            r_num       <= '0;
            r_issued    <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_accept) begin
                r_next_addr <= {base_addr[ADDR_W-1:2], 2'b00};
                r_num       <= num_words;
                r_issued    <= '0;
            end else if (w_issue) begin
                r_next_addr <= r_next_addr + ADDR_W'(4);
                r_last_addr <= r_next_addr;
                r_issued    <= r_issued + CNT_W'(1);
            end
        end
    end

    // Two-entry prefetch FIFO; landing data is always captured, even under stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= sram_rdata;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_fifo_rd) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_fifo_rd})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Common injection stage: a popped word, or zero padding with no valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inj_data  <= '0;
            r_inj_valid <= '0;
        end else if (!stall) begin
            r_inj_valid <= {LANES{w_pop}};
            r_inj_data  <= w_pop ? w_head : '0;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (k == 0) begin : g_direct
            assign w_lane_data[k]  = r_inj_data[LANE_W-1:0];
            assign w_lane_valid[k] = r_inj_valid[k];
            assign w_lane_pend[k]  = 1'b0;
        end else begin : g_delay
            logic w_chain_pend;
            skew_lane_delay #(
                .DEPTH (k),
                .W     (LANE_W)
            ) u_delay (
                .clk       (clk),
                .rst       (reset),
                .i_en      (!stall),
                .i_data    (r_inj_data[k*LANE_W +: LANE_W]),
                .i_valid   (r_inj_valid[k]),
                .o_data    (w_lane_data[k]),
                .o_valid   (w_lane_valid[k]),
                .o_pending (w_chain_pend)
            );
            assign w_lane_pend[k] = r_inj_valid[k] | w_chain_pend;
        end
        assign out_data[k*LANE_W +: LANE_W] = w_lane_data[k];
        assign out_lane_valid[k]            = w_lane_valid[k];
    end

    assign w_pipe_pending = |w_lane_pend;

endmodule
`default_nettype wire

// File: tb/tb_ub_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ub_skew_feeder
// Description : Directed self-checking bench for ub_skew_feeder with an SRAM
//               model and a per-lane byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ub_skew_feeder;
    import ub_skew_feeder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] num_words;
    logic        busy;
    logic        done;
    logic        sram_wen;
    logic [15:0] sram_addr;
    logic [31:0] sram_rdata;
    logic        stall;
    logic [31:0] out_data;
    logic [3:0]  out_lane_valid;

    logic [31:0] mem [16384];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    logic        stall_q = 1'b0;
    bit          mon_en = 1'b0;
    logic [31:0] prev_data = '0;
    logic [3:0]  prev_valid = '0;
    logic [7:0]  q0[$], q1[$], q2[$], q3[$];

    ub_skew_feeder dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .busy           (busy),
        .done           (done),
        .sram_wen       (sram_wen),
        .sram_addr      (sram_addr),
        .sram_rdata     (sram_rdata),
        .stall          (stall),
        .out_data       (out_data),
        .out_lane_valid (out_lane_valid)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM model
    always @(posedge clk) sram_rdata <= mem[sram_addr[15:2]];
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) stall_q <= stall;
    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [15:0] b, input logic [15:0] n);
        logic [15:0] a;
        logic [31:0] w;
        a = {b[15:2], 2'b00};
        for (int i = 0; i < int'(n); i++) begin
            w = mem[a[15:2]];
            q0.push_back(w[7:0]);
            q1.push_back(w[15:8]);
            q2.push_back(w[23:16]);
            q3.push_back(w[31:24]);
            a = a + 16'd4;
        end
    endtask

    task automatic sb_pop(input int k, output logic [7:0] v, output bit ok);
        ok = 1'b0;
        v  = '0;
        case (k)
            0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
            2: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
            default: if (q3.size() > 0) begin v = q3.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic sb_empty(input string tag);
        chk(tag, 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);
    endtask

    // Start pulse for one cycle; s is the cycle in which start is sampled
    task automatic kick(input logic [15:0] b, input logic [15:0] n, output int s);
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        s         = cyc;
        sb_push(b, n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int dc);
        dc = -1;
        for (int i = 0; i < limit; i++) begin
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Output monitor: frozen under stall, otherwise new beats checked against the scoreboard
    always @(negedge clk) begin
        logic [7:0] v;
        bit         ok;
        if (mon_en && !reset) begin
            if (stall_q) begin
                chk("frozen_data", out_data, prev_data);
                chk("frozen_valid", 32'(out_lane_valid), 32'(prev_valid));
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (out_lane_valid[k]) begin
                        sb_pop(k, v, ok);
                        if (!ok) begin
                            checks++;
                            failures++;
                            $error("FAIL extra_beat lane=%0d observed=%0h expected=none", k, out_data[k*8 +: 8]);
                        end else begin
                            chk($sformatf("lane%0d_data", k), 32'(out_data[k*8 +: 8]), 32'(v));
                        end
                    end else begin
                        chk($sformatf("lane%0d_pad", k), 32'(out_data[k*8 +: 8]), 32'd0);
                    end
                end
            end
        end
        prev_data  <= out_data;
        prev_valid <= out_lane_valid;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        int          dc;
        int          dcnt0;
        logic [15:0] addr_prev;

        reset = 1'b1; start = 1'b0; stall = 1'b0;
        base_addr = '0; num_words = '0;
        for (int i = 0; i < 16384; i++) begin
            mem[i] = {8'(i) ^ 8'h5A, 8'(i >> 8) ^ 8'hC3, 8'(i + 3), 8'(i * 7)};
        end
        mem[16'h0100 >> 2]     = 32'h04030201;
        mem[(16'h0100 >> 2)+1] = 32'h08070605;
        mem[(16'h0100 >> 2)+2] = 32'h0C0B0A09;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wen", 32'(sram_wen), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_valid", 32'(out_lane_valid), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // 1: three words, no stall
        kick(16'h0100, 16'd3, s);
        chk("t1_addr0", 32'(sram_addr), 32'h0100);
        chk("t1_wen", 32'(sram_wen), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_addr1", 32'(sram_addr), 32'h0104);
        @(negedge clk);
        chk("t1_addr2", 32'(sram_addr), 32'h0108);
        chk("t1_first_valid", 32'(out_lane_valid), 32'h1);
        chk("t1_first_data", out_data, 32'h00000001);
        repeat (3) @(negedge clk);
        chk("t1_s6_valid", 32'(out_lane_valid), 32'he);
        chk("t1_s6_data", out_data, 32'h04070A00);
        wait_done(20, dc);
        chk("t1_done_cycle", 32'(dc), 32'(s + 9));
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);
        sb_empty("t1_drained");

        // 2: zero-length request
        addr_prev = sram_addr;
        kick(16'h0200, 16'd0, s);
        wait_done(4, dc);
        chk("t2_done_cycle", 32'(dc), 32'(s + 1));
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_addr", 32'(sram_addr), 32'(addr_prev));
        chk("t2_valid", 32'(out_lane_valid), 32'd0);
        @(negedge clk);
        chk("t2_busy_after", 32'(busy), 32'd0);

        // 3: eight words with stall over S+4..S+9
        @(negedge clk);
        kick(16'h0400, 16'd8, s);
        while (cyc < s + 4) @(negedge clk);
        stall = 1'b1;
        while (cyc < s + 10) @(negedge clk);
        stall = 1'b0;
        wait_done(40, dc);
        chk("t3_done_cycle", 32'(dc), 32'(s + 20));
        sb_empty("t3_drained");
        @(negedge clk);

        // 4: address wrap
        kick(16'hFFF8, 16'd4, s);
        chk("t4_addr0", 32'(sram_addr), 32'hFFF8);
        @(negedge clk);
        chk("t4_addr1", 32'(sram_addr), 32'hFFFC);
        @(negedge clk);
        chk("t4_addr2", 32'(sram_addr), 32'h0000);
        @(negedge clk);
        chk("t4_addr3", 32'(sram_addr), 32'h0004);
        wait_done(20, dc);
        chk("t4_done_cycle", 32'(dc), 32'(s + 10));
        @(negedge clk);
        sb_empty("t4_drained");

        // 5: asynchronous abort mid-stream, then a fresh one-word run
        kick(16'h0800, 16'd10, s);
        while (cyc < s + 4) @(negedge clk);
        mon_en = 1'b0;
        dcnt0  = done_cnt;
        #2 reset = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_addr", 32'(sram_addr), 32'd0);
        chk("t5_data", out_data, 32'd0);
        chk("t5_valid", 32'(out_lane_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        @(negedge clk);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt), 32'(dcnt0));
        chk("t5_idle", 32'(busy), 32'd0);
        kick(16'h0900, 16'd1, s);
        wait_done(20, dc);
        chk("t5_restart_done", 32'(dc), 32'(s + 7));
        @(negedge clk);
        sb_empty("t5_drained");

        // 6: start while busy is ignored
        kick(16'h0A00, 16'd4, s);
        chk("t6_busy", 32'(busy), 32'd1);
        start = 1'b1; base_addr = 16'h0B00; num_words = 16'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(20, dc);
        chk("t6_done_cycle", 32'(dc), 32'(s + 10));
        repeat (6) @(negedge clk);
        chk("t6_idle", 32'(busy), 32'd0);
        sb_empty("t6_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
